// File: rtl/bsg_adder_cin_pipelined.sv
// Pipelined adder with carry-in: the carry chain is cut into stages_p segments, one resolved per cycle.
// Define BSG_ADDER_CIN_PIPELINED_OVF_EN to add the registered signed-overflow output ovf_o.
module bsg_adder_cin_pipelined #(
  parameter int width_p  = 64,
  parameter int stages_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               cin_i,
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] o,
  output logic               cout_o
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
  ,
  output logic               ovf_o
`endif
);

  localparam int SEG_W = width_p / stages_p;

  logic w_en;

  genvar k;
  for (k = 0; k < stages_p; k++) begin : g_stage
    localparam int LO    = k * SEG_W;
    localparam int HI    = LO + SEG_W;
    localparam int SRC_W = width_p - LO;

    logic               w_vIn;
    logic               w_cIn;
    logic [SRC_W-1:0]   w_aSrc;
    logic [SRC_W-1:0]   w_bSrc;
    logic [SEG_W:0]     w_segSum;
    logic [HI-1:0]      w_sumNext;

    logic               r_v;
    logic               r_c;
    logic [HI-1:0]      r_sum;

    // Operand sources: the raw inputs for stage 0, otherwise whatever segments the previous stage still holds
    if (k == 0) begin : g_head
      assign w_vIn     = v_i;
      assign w_cIn     = cin_i;
      assign w_aSrc    = a_i;
      assign w_bSrc    = b_i;
      assign w_sumNext = w_segSum[SEG_W-1:0];
    end else begin : g_body
      assign w_vIn     = g_stage[k-1].r_v;
      assign w_cIn     = g_stage[k-1].r_c;
      assign w_aSrc    = g_stage[k-1].g_ops.r_a;
      assign w_bSrc    = g_stage[k-1].g_ops.r_b;
      assign w_sumNext = {w_segSum[SEG_W-1:0], g_stage[k-1].r_sum};
    end

    assign w_segSum = {1'b0, w_aSrc[SEG_W-1:0]} + {1'b0, w_bSrc[SEG_W-1:0]}
                    + {{SEG_W{1'b0}}, w_cIn};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_en) begin
        r_v   <= w_vIn;
        r_c   <= w_segSum[SEG_W];
        r_sum <= w_sumNext;
      end
    end

    // Only the not-yet-consumed upper segments travel on, so these registers shrink stage by stage
    if (k < stages_p - 1) begin : g_ops
      logic [SRC_W-SEG_W-1:0] r_a;
      logic [SRC_W-SEG_W-1:0] r_b;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_aSrc[SRC_W-1:SEG_W];
          r_b <= w_bSrc[SRC_W-1:SEG_W];
        end
      end
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
    end else begin : g_tail
      logic w_msbCarryIn;
      logic r_ovf;

      // The carry into the MSB is recovered from the MSB operand bits and the MSB sum bit
      assign w_msbCarryIn = w_aSrc[SEG_W-1] ^ w_bSrc[SEG_W-1] ^ w_segSum[SEG_W-1];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_msbCarryIn ^ w_segSum[SEG_W];
        end
      end

      assign ovf_o = r_ovf;
`endif
    end
  end

  // One global enable: the whole pipe advances unless a finished result is waiting on the consumer
  assign w_en    = ~v_o | ready_i;
  assign ready_o = w_en;
  assign v_o     = g_stage[stages_p-1].r_v;
  assign o       = g_stage[stages_p-1].r_sum;
  assign cout_o  = g_stage[stages_p-1].r_c;

endmodule

// File: tb/tb_bsg_adder_cin_pipelined.sv
// Self-checking bench for bsg_adder_cin_pipelined: five instances (stages 4, 1, 2, 8, 64) share one
// input stream and are each scored against a 65-bit arithmetic reference model.
module tb_bsg_adder_cin_pipelined;

  localparam int W     = 64;
  localparam int N     = 5;
  localparam int DEPTH = 512;

  int stg [N] = '{4, 1, 2, 8, 64};

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         reset_n_i;
  logic         v_i;
  logic         cin_i;
  logic         ready_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;

  logic         readyO [N];
  logic         vO     [N];
  logic         coutO  [N];
  logic [W-1:0] oO     [N];
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
  logic         ovfO   [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 64;
    bsg_adder_cin_pipelined #(.width_p(W), .stages_p(S)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .ready_o   (readyO[g]),
      .a_i       (a_i),
      .b_i       (b_i),
      .cin_i     (cin_i),
      .v_o       (vO[g]),
      .ready_i   (ready_i),
      .o         (oO[g]),
      .cout_o    (coutO[g])
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
      ,
      .ovf_o     (ovfO[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W+1:0] expQ [N][DEPTH];
  int           accQ [N][DEPTH];
  int           wrPtr [N];
  int           rdPtr [N];
  int           lastStall [N];

  // Reference: {overflow, carry-out, sum} from plain wide arithmetic
  function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic bit busy();
    for (int d = 0; d < N; d++)
      if (rdPtr[d] != wrPtr[d]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clearBoard();
    for (int d = 0; d < N; d++) begin
      wrPtr[d]     = 0;
      rdPtr[d]     = 0;
      lastStall[d] = -1;
    end
  endtask

  // One clock cycle: drive, score every instance's handshake and result, then advance
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic rdy);
    logic [W+1:0] e;
    v_i = v; a_i = a; b_i = b; cin_i = cin; ready_i = rdy;
    #2;
    for (int d = 0; d < N; d++) begin
      if (rdy) begin
        checks++;
        if (readyO[d] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ready_o dut%0d cyc%0d: got %b, expected 1", d, cyc, readyO[d]);
        end
      end
      if (vO[d] === 1'b1) begin
        if (rdPtr[d] == wrPtr[d]) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_v_o dut%0d cyc%0d: got v_o=1, expected 0", d, cyc);
        end else begin
          e = expQ[d][rdPtr[d] % DEPTH];
          checks++;
          if ({coutO[d], oO[d]} !== e[W:0]) begin
            errors++;
            $display("[TB] FAIL sum dut%0d cyc%0d: got %h, expected %h", d, cyc,
                     {coutO[d], oO[d]}, e[W:0]);
          end
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
          checks++;
          if (ovfO[d] !== e[W+1]) begin
            errors++;
            $display("[TB] FAIL ovf dut%0d cyc%0d: got %b, expected %b", d, cyc, ovfO[d], e[W+1]);
          end
`endif
          if (!rdy) begin
            lastStall[d] = cyc;
            checks++;
            if (readyO[d] !== 1'b0) begin
              errors++;
              $display("[TB] FAIL stall_ready dut%0d cyc%0d: got %b, expected 0", d, cyc, readyO[d]);
            end
          end else begin
            if (accQ[d][rdPtr[d] % DEPTH] > lastStall[d]) begin
              checks++;
              if (cyc - accQ[d][rdPtr[d] % DEPTH] != stg[d]) begin
                errors++;
                $display("[TB] FAIL latency dut%0d: got %0d, expected %0d", d,
                         cyc - accQ[d][rdPtr[d] % DEPTH], stg[d]);
              end
            end
            rdPtr[d]++;
          end
        end
      end
      if (v && readyO[d] === 1'b1) begin
        expQ[d][wrPtr[d] % DEPTH] = refModel(a, b, cin);
        accQ[d][wrPtr[d] % DEPTH] = cyc;
        wrPtr[d]++;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && busy(); i++)
      cycle(1'b0, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (rdPtr[d] != wrPtr[d]) begin
        errors++;
        $display("[TB] FAIL drain dut%0d: got %0d results, expected %0d", d, rdPtr[d], wrPtr[d]);
      end
    end
  endtask

  task automatic checkCleared(input string tag);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (vO[d] !== 1'b0 || oO[d] !== '0 || coutO[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s dut%0d: got v_o=%b o=%h cout=%b, expected all 0", tag, d,
                 vO[d], oO[d], coutO[d]);
      end
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
      checks++;
      if (ovfO[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_ovf dut%0d: got %b, expected 0", tag, d, ovfO[d]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    v_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; ready_i = 1'b1;
    reset_n_i = 1'b1;
    #1;
    reset_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkCleared("reset_state");
    clearBoard();
    reset_n_i = 1'b1;
  endtask

  task automatic test_carry_ripple();
    cycle(1'b1, {W{1'b1}}, '0, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1);
    drain();
  endtask

  task automatic test_random_handshake();
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(9) < 7), rnd64(), rnd64(), 1'($urandom_range(1)),
            1'($urandom_range(9) < 6));
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1);
    #2;
    reset_n_i = 1'b0;
    #1;
    checkCleared("midflight_reset");
    @(posedge clk_i);
    #1;
    clearBoard();
    reset_n_i = 1'b1;
    cycle(1'b1, rnd64(), rnd64(), 1'b1, 1'b1);
    drain();
  endtask

`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
  task automatic test_ovf();
    cycle(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    cycle(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    cycle(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    drain();
  endtask
`endif

  task automatic test_sweep();
    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 3)
        cycle(1'b1, {W{1'b1}}, rnd64(), 1'b1, 1'b1);
      else
        cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_carry_ripple();
    test_back_to_back();
    test_backpressure();
    test_random_handshake();
    test_reset_midflight();
`ifdef BSG_ADDER_CIN_PIPELINED_OVF_EN
    test_ovf();
`endif
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_adder_cin_pipelined.md
# bsg_adder_cin_pipelined

Pipelined two-operand adder with carry-in, generalised in operand width and pipeline depth, with a valid/ready handshake on both sides. The carry chain is split into `stages_p` equal segments, one segment resolved per cycle, giving one result per cycle at `stages_p` cycles latency. It sits wherever a wide add with carry-in would otherwise set the critical path, e.g. datapath accumulators and wide counters.

## Interface
- `width_p`, 64, operand and result width in bits.
- `stages_p`, 4, number of pipeline stages and carry segments. Must be in 1..`width_p` and must divide `width_p`. Segment width is `seg_w = width_p/stages_p`.

- `clk_i`  in  1  clock; all state on rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `v_i`  in  1  input operands valid.
- `ready_o`  out  1  block accepts the input this cycle.
- `a_i`  in  `width_p`  operand A.
- `b_i`  in  `width_p`  operand B.
- `cin_i`  in  1  carry-in.
- `v_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts the result this cycle.
- `o`  out  `width_p`  sum, `(a_i + b_i + cin_i) mod 2^width_p`.
- `cout_o`  out  1  carry-out, bit `width_p` of the full sum.
- `ovf_o`  out  1  signed overflow; present only with `BSG_ADDER_CIN_PIPELINED_OVF_EN`.

## Operation
- Input transfer: `v_i & ready_o`. Output transfer: `v_o & ready_i`.
- Global advance enable `en = ~v_o | ready_i`; `ready_o = en`. All stages shift together when `en`=1 and hold when `en`=0. Bubbles are not collapsed.
- Stage k (0-based) register holds: valid bit, sum bits for segments 0..k, the unconsumed upper operand segments k+1..`stages_p`-1 of A and B, and the carry out of segment k.
- Stage 0 loads `a_i[seg0] + b_i[seg0] + cin_i`. Stage k adds segment k of the carried operands plus the stage k-1 carry.
- `o` = final-stage sum register. `cout_o` = final-stage carry.
- If `stages_p`=1, the block is a single registered full-width adder with the same handshake.
- Operand segment registers shrink by one segment per stage. Operands already consumed are not carried forward.
- Arithmetic is unsigned modulo 2^`width_p`. All 1s + 0 + cin=1 gives `o`=0, `cout_o`=1.

## Timing
- Reset (`reset_n_i`=0, asynchronous): all valid bits, sum, carry and operand registers are cleared to 0. `v_o`=0, `o`=0, `cout_o`=0 and `ovf_o`=0. `ready_o`=1 while in reset is don't-care. `ready_o`=1 in the first cycle after deassertion.
- Reset asserted mid-operation discards all in-flight results with no partial output.
- Latency is exactly `stages_p` cycles from input transfer to `v_o`=1, assuming no stalls.
- Throughput is 1 result/cycle while `ready_i`=1.
- Stall: `v_o`=1 & `ready_i`=0 freezes every stage. `o`, `cout_o` and `v_o` stay stable until transfer, and `ready_o`=0.
- Simultaneous output transfer and input transfer in the same cycle is allowed and required for full throughput.
- `ready_o` depends combinationally on `ready_i`. There is no path from `v_i` to `ready_o`.
- Order is preserved, first in first out.

## Configuration
- `BSG_ADDER_CIN_PIPELINED_OVF_EN` defined: port `ovf_o` exists. Its value is the final-stage carry into the MSB XOR `cout_o`, registered and aligned with `o`, with the same stall and reset behaviour.
- Macro not defined: port `ovf_o` and its pipeline bit are absent. All other behaviour is identical.

## Test plan
- Reset then single op, `width_p`=64, `stages_p`=4: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → `v_o`=1 exactly 4 cycles after accept, `o`=0, `cout_o`=1, carry rippled through all segments.
- Back-to-back stream of 16 random ops with `ready_i`=1 → 16 consecutive `v_o` cycles, each `o`/`cout_o` matching the 65-bit reference sum, in order.
- Backpressure: hold `ready_i`=0 for 5 cycles while the pipe is full → `ready_o`=0, `o` stable, no result lost or duplicated after release.
- Reset asserted while 3 ops are in flight → `v_o`=0 and `o`=0 immediately (asynchronously). The first post-reset op completes with the correct value.
- With `OVF_EN`: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → `o`=0x8000_0000_0000_0000, `ovf_o`=1, `cout_o`=0. Also a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 → `o`=0, `ovf_o`=1, `cout_o`=1.
- Parameter sweep `stages_p` ∈ {1, 2, 8, 64} with `width_p`=64: random ops → latency equals `stages_p`, and all sums are correct.
